// File: rtl/lcd4_stream_ctrl.sv
// HD44780-style 4-bit LCD controller: autonomous power-on init, then streams
// FIFO-buffered command/data bytes to the panel as high/low nibble pairs.
module lcd4_stream_ctrl #(
    parameter int DEPTH       = 8,
    parameter int T_POWERUP   = 750000,
    parameter int T_INIT_LONG = 205000,
    parameter int T_AS        = 2,
    parameter int T_EH        = 12,
    parameter int T_H         = 2,
    parameter int T_NIB       = 50,
    parameter int T_CMD       = 2000,
    parameter int T_CLEAR     = 82000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_rs,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic                       lcd_e,
    output logic                       lcd_rs,
    output logic                       lcd_rw,
    output logic                       lcd_4,
    output logic                       lcd_5,
    output logic                       lcd_6,
    output logic                       lcd_7,
    output logic                       init_done,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int LW      = $clog2(DEPTH + 1);
    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_MAX = max_i(max_i(max_i(T_POWERUP, T_INIT_LONG), max_i(T_CLEAR, T_CMD)),
                                   max_i(max_i(T_AS, T_EH), max_i(T_H, T_NIB)));
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] L_POWERUP   = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] L_INIT_LONG = CW'(T_INIT_LONG - 1);
    localparam logic [CW-1:0] L_AS        = CW'(T_AS - 1);
    localparam logic [CW-1:0] L_EH        = CW'(T_EH - 1);
    localparam logic [CW-1:0] L_H         = CW'(T_H - 1);
    localparam logic [CW-1:0] L_NIB       = CW'(T_NIB - 1);
    localparam logic [CW-1:0] L_CMD       = CW'(T_CMD - 1);
    localparam logic [CW-1:0] L_CLEAR     = CW'(T_CLEAR - 1);

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_IDLE,
        S_SETUP,
        S_E_HIGH,
        S_HOLD,
        S_NIB_GAP,
        S_CMD_WAIT
    } state_t;

    // Steps 0..3 are single init nibbles (upper half only), 4..7 are full bytes.
    function automatic logic [7:0] init_byte(input logic [2:0] step);
        case (step)
            3'd0, 3'd1, 3'd2: return 8'h30;
            3'd3:             return 8'h20;
            3'd4:             return 8'h28;
            3'd5:             return 8'h0C;
            3'd6:             return 8'h06;
            default:          return 8'h01;
        endcase
    endfunction

    // ---------------- request FIFO ----------------
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          push, pop;
    logic [8:0]    head;

    assign in_ready = (level != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    // NOTE: storage carries no reset; occupancy is tracked by level, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_rs, in_data};
    end

    // NOTE: every clocked register uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
        end
    end

    // ---------------- sequencer ----------------
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    cur_byte, cur_byte_n;
    logic          cur_rs, cur_rs_n;
    logic          low, low_n;
    logic          single, single_n;
    logic [2:0]    step, step_n;
    logic [3:0]    nib, nib_n;
    logic          done, done_n;

    logic          start, start_rs, start_single;
    logic [7:0]    start_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_PWR_WAIT;
            cnt      <= L_POWERUP;
            cur_byte <= '0;
            cur_rs   <= 1'b0;
            low      <= 1'b0;
            single   <= 1'b0;
            step     <= '0;
            nib      <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cur_byte <= cur_byte_n;
            cur_rs   <= cur_rs_n;
            low      <= low_n;
            single   <= single_n;
            step     <= step_n;
            nib      <= nib_n;
            done     <= done_n;
        end
    end

    // NOTE: every signal driven here gets a default first, so no latches are inferred.
    always_comb begin
        state_n      = state;
        cnt_n        = (cnt == '0) ? cnt : cnt - CW'(1);
        cur_byte_n   = cur_byte;
        cur_rs_n     = cur_rs;
        low_n        = low;
        single_n     = single;
        step_n       = step;
        nib_n        = nib;
        done_n       = done;
        pop          = 1'b0;
        start        = 1'b0;
        start_byte   = head[7:0];
        start_rs     = head[8];
        start_single = 1'b0;

        case (state)
            S_PWR_WAIT: begin
                if (cnt == '0) begin
                    start        = 1'b1;
                    start_byte   = init_byte(3'd0);
                    start_rs     = 1'b0;
                    start_single = 1'b1;
                end
            end
            S_IDLE: begin
                if (done && level != '0) begin
                    pop   = 1'b1;
                    start = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_n = S_E_HIGH;
                    cnt_n   = L_EH;
                end
            end
            S_E_HIGH: begin
                if (cnt == '0) begin
                    state_n = S_HOLD;
                    cnt_n   = L_H;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    if (!single && !low) begin
                        state_n = S_NIB_GAP;
                        cnt_n   = L_NIB;
                    end else begin
                        state_n = S_CMD_WAIT;
                        if (single && step == 3'd0)
                            cnt_n = L_INIT_LONG;
                        else if (!single && !cur_rs && (cur_byte == 8'h01 || cur_byte == 8'h02))
                            cnt_n = L_CLEAR;
                        else
                            cnt_n = L_CMD;
                    end
                end
            end
            S_NIB_GAP: begin
                if (cnt == '0) begin
                    state_n = S_SETUP;
                    cnt_n   = L_AS;
                    low_n   = 1'b1;
                    nib_n   = cur_byte[3:0];
                end
            end
            S_CMD_WAIT: begin
                if (cnt == '0) begin
                    if (!done) begin
                        if (step == 3'd7) begin
                            state_n = S_IDLE;
                            done_n  = 1'b1;
                        end else begin
                            step_n       = step + 3'd1;
                            start        = 1'b1;
                            start_byte   = init_byte(step + 3'd1);
                            start_rs     = 1'b0;
                            start_single = ~step_n[2];
                        end
                    end else if (level != '0) begin
                        // Chain straight into the next queued byte without an IDLE cycle.
                        pop   = 1'b1;
                        start = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_PWR_WAIT;
                cnt_n   = L_POWERUP;
            end
        endcase

        if (start) begin
            state_n    = S_SETUP;
            cnt_n      = L_AS;
            cur_byte_n = start_byte;
            cur_rs_n   = start_rs;
            single_n   = start_single;
            low_n      = 1'b0;
            nib_n      = start_byte[7:4];
        end
    end

    assign lcd_e                      = (state == S_E_HIGH);
    assign lcd_rs                     = cur_rs;
    assign lcd_rw                     = 1'b0;
    assign {lcd_7, lcd_6, lcd_5, lcd_4} = nib;
    assign init_done                  = done;
    assign busy                       = (state != S_IDLE) || (level != '0);
    assign fifo_level                 = level;

endmodule

// File: tb/tb_lcd4_stream_ctrl.sv
// Directed bench for lcd4_stream_ctrl: init sequence timing, nibble streaming,
// FIFO handshake limits and async reset, against hand-computed expectations.
module tb_lcd4_stream_ctrl;

    localparam int DEPTH       = 4;
    localparam int T_POWERUP   = 20;
    localparam int T_INIT_LONG = 10;
    localparam int T_AS        = 2;
    localparam int T_EH        = 3;
    localparam int T_H         = 2;
    localparam int T_NIB       = 4;
    localparam int T_CMD       = 8;
    localparam int T_CLEAR     = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, lcd_e, lcd_rs, lcd_rw, lcd_4, lcd_5, lcd_6, lcd_7;
    logic       init_done, busy;
    logic [2:0] fifo_level;

    lcd4_stream_ctrl #(
        .DEPTH(DEPTH), .T_POWERUP(T_POWERUP), .T_INIT_LONG(T_INIT_LONG), .T_AS(T_AS),
        .T_EH(T_EH), .T_H(T_H), .T_NIB(T_NIB), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs(in_rs), .in_data(in_data),
        .in_ready(in_ready), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_4(lcd_4), .lcd_5(lcd_5), .lcd_6(lcd_6), .lcd_7(lcd_7),
        .init_done(init_done), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic       rs;
        logic [3:0] nib;
    } pulse_t;

    pulse_t     pulses[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic       prev_e = 1'b0;
    int         rise_t = 0;
    logic [3:0] rise_nib = 4'h0;
    wire  [3:0] nib = {lcd_7, lcd_6, lcd_5, lcd_4};

    // Init pulse rise times (cycles after reset release) and nibbles.
    int         exp_t[12] = '{22, 39, 54, 69, 84, 95, 110, 121, 136, 147, 162, 173};
    logic [3:0] exp_n[12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pulse recorder; also checks strobe width and data stability over each strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (lcd_e && !prev_e) begin
                pulses.push_back('{cyc, lcd_rs, nib});
                rise_t   = cyc;
                rise_nib = nib;
            end
            if (!lcd_e && prev_e) begin
                check("e_width", cyc - rise_t, T_EH);
                check("e_data_hold", {28'd0, nib}, {28'd0, rise_nib});
            end
        end
        prev_e = lcd_e;
    end

    task automatic push(input logic rs, input logic [7:0] d, output int hs);
        @(negedge clk);
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = d;
        @(posedge clk);
        #1;
        hs       = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int n);
        int k = 0;
        while (pulses.size() < n && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("pulse_count", pulses.size(), n);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic expect_pulse(input string tag, input int idx, input logic rs, input logic [3:0] n);
        if (idx >= pulses.size()) begin
            check(tag, 0, 1);
        end else begin
            check({tag, "_rs"}, pulses[idx].rs, rs);
            check({tag, "_nib"}, {28'd0, pulses[idx].nib}, {28'd0, n});
        end
    endtask

    task automatic check_init(input int rel);
        int k = 0;
        while (!init_done && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("init_done_time", cyc - rel, 208);
        wait_pulses(12);
        for (int i = 0; i < 12; i++) begin
            if (i < pulses.size()) check("init_rise_time", pulses[i].t - rel, exp_t[i]);
            expect_pulse("init_pulse", i, 1'b0, exp_n[i]);
        end
    endtask

    int         rel, hs, h1, k;
    logic [7:0] t3_vals[5] = '{8'h31, 8'h52, 8'h73, 8'h94, 8'hB5};
    logic [3:0] t6_nibs[12] = '{4'h6, 4'h1, 4'h6, 4'h2, 4'h6, 4'h3, 4'h6, 4'h4, 4'h6, 4'h5, 4'hF, 4'h0};

    initial begin
        // ---- 1: reset state and autonomous init ----
        repeat (3) @(negedge clk);
        check("rst_lcd_e", lcd_e, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_nib", {28'd0, nib}, 0);
        check("rst_init_done", init_done, 0);
        check("rst_level", {29'd0, fifo_level}, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 1);
        rst = 1'b0;
        rel = cyc;
        pulses.delete();
        check_init(rel);
        check("init_done_busy", busy, 0);

        // ---- 2: single data byte ----
        wait_idle();
        pulses.delete();
        push(1'b1, 8'h41, hs);
        wait_pulses(2);
        if (pulses.size() >= 2) begin
            check("t2_rise_hi", pulses[0].t - hs, 3);
            check("t2_rise_lo", pulses[1].t - hs, 14);
        end
        expect_pulse("t2_hi", 0, 1'b1, 4'h4);
        expect_pulse("t2_lo", 1, 1'b1, 4'h1);
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t2_busy_drop", cyc - hs, 27);

        // ---- 4: post-byte wait after clear vs ordinary command ----
        wait_idle();
        pulses.delete();
        push(1'b0, 8'h01, h1);
        push(1'b1, 8'h42, hs);
        wait_pulses(4);
        if (pulses.size() >= 4) begin
            check("t4_first_rise", pulses[0].t - h1, 3);
            check("t4_clear_gap", pulses[2].t - pulses[1].t, 37);
        end
        expect_pulse("t4_01_hi", 0, 1'b0, 4'h0);
        expect_pulse("t4_01_lo", 1, 1'b0, 4'h1);
        expect_pulse("t4_42_hi", 2, 1'b1, 4'h4);
        expect_pulse("t4_42_lo", 3, 1'b1, 4'h2);
        wait_idle();
        pulses.delete();
        push(1'b0, 8'h80, h1);
        push(1'b1, 8'h42, hs);
        wait_pulses(4);
        if (pulses.size() >= 4) check("t4_cmd_gap", pulses[2].t - pulses[1].t, 15);
        expect_pulse("t4_80_hi", 0, 1'b0, 4'h8);
        expect_pulse("t4_80_lo", 1, 1'b0, 4'h0);
        expect_pulse("t4_42b_hi", 2, 1'b1, 4'h4);

        // ---- 6: push while full coinciding with a pop ----
        wait_idle();
        pulses.delete();
        push(1'b1, 8'h61, hs);
        push(1'b1, 8'h62, hs);
        push(1'b1, 8'h63, hs);
        push(1'b1, 8'h64, hs);
        push(1'b1, 8'h65, hs);
        @(negedge clk);
        check("t6_full_level", {29'd0, fifo_level}, 4);
        check("t6_full_ready", in_ready, 0);
        in_valid = 1'b1;
        in_rs    = 1'b1;
        in_data  = 8'hEE;
        k = 0;
        while (fifo_level == 3'd4 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t6_level_after_pop", {29'd0, fifo_level}, 3);
        check("t6_ready_after_pop", in_ready, 1);
        in_data = 8'hF0;
        @(negedge clk);
        in_valid = 1'b0;
        check("t6_level_refill", {29'd0, fifo_level}, 4);
        wait_pulses(12);
        for (int i = 0; i < 12; i++) expect_pulse("t6_order", i, 1'b1, t6_nibs[i]);

        // ---- 5: async reset while strobe is high ----
        wait_idle();
        pulses.delete();
        push(1'b1, 8'h55, hs);
        push(1'b1, 8'h66, hs);
        push(1'b1, 8'h77, hs);
        k = 0;
        while (!lcd_e && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t5_e_seen", lcd_e, 1);
        check("t5_level_before", {29'd0, fifo_level}, 2);
        #2;
        rst = 1'b1;
        #1;
        check("t5_e_dropped", lcd_e, 0);
        check("t5_level_flushed", {29'd0, fifo_level}, 0);
        check("t5_init_done", init_done, 0);
        check("t5_busy", busy, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        pulses.delete();

        // ---- 3: overfill during init, drain after init_done ----
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_ready", in_ready, (i < 4) ? 1 : 0);
            in_valid = 1'b1;
            in_rs    = 1'b1;
            in_data  = t3_vals[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("t3_level", {29'd0, fifo_level}, 4);
        check("t3_ready_full", in_ready, 0);
        check_init(rel);
        wait_pulses(20);
        expect_pulse("t3_b0_hi", 12, 1'b1, 4'h3);
        expect_pulse("t3_b0_lo", 13, 1'b1, 4'h1);
        expect_pulse("t3_b1_hi", 14, 1'b1, 4'h5);
        expect_pulse("t3_b1_lo", 15, 1'b1, 4'h2);
        expect_pulse("t3_b2_hi", 16, 1'b1, 4'h7);
        expect_pulse("t3_b2_lo", 17, 1'b1, 4'h3);
        expect_pulse("t3_b3_hi", 18, 1'b1, 4'h9);
        expect_pulse("t3_b3_lo", 19, 1'b1, 4'h4);
        wait_idle();
        repeat (20) @(negedge clk);
        check("t3_no_fifth", pulses.size(), 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lcd4_stream_ctrl.md
Name: lcd4_stream_ctrl

Overview:
- Parametrised HD44780-style 4-bit LCD controller; successor to the fixed-timing LCD driver in the Lab3 top level.
- Performs the power-on init sequence autonomously, then streams queued command/data bytes to the panel as nibble pairs.
- All timings are cycle-count parameters. Requests are buffered in a DEPTH-entry FIFO behind a valid/ready handshake, so system logic never stalls on LCD timing.

Parameters:
- DEPTH, 8: FIFO entries, each {rs, data[7:0]}; power of two, ≥2.
- T_POWERUP, 750000: cycles from reset release to the first init nibble.
- T_INIT_LONG, 205000: wait after the first 0x3 init nibble.
- T_AS, 2: cycles rs/data are stable before lcd_e rises.
- T_EH, 12: lcd_e high cycles.
- T_H, 2: cycles rs/data are held after lcd_e falls.
- T_NIB, 50: gap between the high and low nibble of one byte.
- T_CMD, 2000: wait after a byte, or after a short init nibble.
- T_CLEAR, 82000: wait after command 0x01 or 0x02 (rs=0).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: request byte present.
- in_rs, in, 1: 0=command, 1=data.
- in_data, in, 8: byte to write.
- in_ready, out, 1: FIFO not full.
- lcd_e, out, 1: enable strobe.
- lcd_rs, out, 1: register select.
- lcd_rw, out, 1: tied 0 (write only).
- lcd_4, lcd_5, lcd_6, lcd_7, out, 1 each: data nibble bits 0..3.
- init_done, out, 1: init sequence complete.
- busy, out, 1: FSM not IDLE or FIFO non-empty.
- fifo_level, out, $clog2(DEPTH+1): occupied entries.

Behaviour:
- Reset (async assert, sync release): lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_4..7=0, init_done=0, fifo_level=0, in_ready=1, busy=1, state=PWR_WAIT.
  - Reset mid-nibble drops lcd_e immediately, flushes the FIFO and restarts the full init.
- Handshake:
  - Push when in_valid && in_ready at a clk edge. in_ready = (fifo_level != DEPTH), registered-level based.
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - Pushes are accepted during init and held until init_done.
  - A simultaneous push and pop leaves fifo_level unchanged.
- FSM: PWR_WAIT -> INIT_NIB -> INIT_WAIT -> (repeat) -> IDLE -> SETUP -> E_HIGH -> HOLD -> NIB_GAP -> SETUP(low) -> E_HIGH -> HOLD -> CMD_WAIT -> IDLE.
- Init, all rs=0:
  - Wait T_POWERUP.
  - Nibble 0x3, wait T_INIT_LONG.
  - Nibble 0x3, wait T_CMD. Nibble 0x3, wait T_CMD. Nibble 0x2, wait T_CMD.
  - Then internal bytes 0x28, 0x0C, 0x06, 0x01; the 0x01 is followed by T_CLEAR.
  - init_done rises on the cycle the FSM enters IDLE after that wait and stays 1 until reset.
- Nibble timing:
  - SETUP drives lcd_rs and lcd_7..4 for T_AS cycles with lcd_e=0.
  - E_HIGH holds lcd_e=1 for exactly T_EH cycles.
  - HOLD keeps lcd_e=0 with data unchanged for T_H cycles.
  - High nibble first. NIB_GAP lasts T_NIB cycles, with data and rs held.
- Post-byte wait: T_CLEAR if rs=0 and byte ∈ {0x01, 0x02}, else T_CMD. lcd_e=0 and data lines hold their last value throughout.
- Pop and latency:
  - In IDLE with FIFO non-empty, the FSM pops the head and enters SETUP on the next edge.
  - For a push at edge N into an empty FIFO while idle: SETUP begins at edge N+1 and lcd_e rises at edge N+1+T_AS.
  - Back-to-back bytes: the next SETUP starts on the cycle after CMD_WAIT expires, with no extra IDLE cycle.
- Counters: a single down-counter sized for max(T_POWERUP, T_INIT_LONG, T_CLEAR). Each state lasts exactly its parameter in cycles (value ≥1).
- FIFO pointers wrap modulo DEPTH; fifo_level ranges 0..DEPTH.

Test Plan:
Overrides: DEPTH=4, T_POWERUP=20, T_INIT_LONG=10, T_AS=2, T_EH=3, T_H=2, T_NIB=4, T_CMD=8, T_CLEAR=30.
1. Reset release, no input -> 4 single-nibble e-pulses (0x3, 0x3, 0x3, 0x2), then 8 byte e-pulses (0x28, 0x0C, 0x06, 0x01) with rs=0. The first e-pulse rises 20+2 cycles after release. init_done=1 exactly 30 cycles after the last 0x01 pulse's HOLD ends.
2. After init, push {rs=1, 0x41} -> lcd_e rises 3 cycles after the handshake edge with lcd_7..4=0x4, rs=1, high for 3 cycles. The second pulse shows 0x1. busy returns to 0 8 cycles after the final HOLD.
3. Push 5 bytes back-to-back during init -> the first 4 are accepted, in_ready=0, the 5th is ignored. fifo_level=4, and all 4 bytes are emitted in order after init_done.
4. Push command 0x01 then data 0x42 -> a 30-cycle gap after the 0x01 low nibble, then 0x42 nibbles. Repeat with 0x80 -> an 8-cycle gap.
5. Assert rst while lcd_e=1 on a data byte -> lcd_e=0 within the same cycle (async). fifo_level=0, init_done=0, and the init sequence restarts from PWR_WAIT.
6. With the FIFO full, push while the FSM pops -> level stays 3 after the pop and the push is dropped. Then a push next cycle is accepted and level=4.
